// File: rtl/mem_arbiter_rr_if.sv
// PicoRV32-native memory bus: one request/response channel between a master and a slave.
interface mem_arbiter_rr_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter sharing one single-port SRAM between two PicoRV32-style masters.
// Every transfer walks IDLE -> BUSY -> TURN; the TURN cycle swallows the SRAM's
// trailing ready, and a watchdog aborts a transfer the slave never answers.
module mem_arbiter_rr #(
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_arbiter_rr_if.slave  m0,
  mem_arbiter_rr_if.slave  m1,
  mem_arbiter_rr_if.master s,
  output logic             grant,
  output logic             timeout_err
);

  localparam int             CW        = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]  WDOG_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          prefer;
  logic [CW-1:0] wdog;
  logic          do_grant;
  logic          grant_idx;
  logic          do_done;
  logic          do_abort;

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and arbitration decisions; the registered datapath below acts on them.
  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    grant_idx  = prefer;
    do_done    = 1'b0;
    do_abort   = 1'b0;
    unique case (state)
      IDLE: begin
        if (m0.mem_valid && m1.mem_valid) begin
          do_grant  = 1'b1;
          grant_idx = prefer;
        end else if (m0.mem_valid) begin
          do_grant  = 1'b1;
          grant_idx = 1'b0;
        end else if (m1.mem_valid) begin
          do_grant  = 1'b1;
          grant_idx = 1'b1;
        end
        if (do_grant) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (s.mem_ready) begin
          do_done = 1'b1;
        end else if (wdog == WDOG_LAST) begin
          do_abort = 1'b1;
        end
        if (do_done || do_abort) begin
          state_next = TURN;
        end
      end
      TURN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered outputs: latch the winner's request, then return its data and a one-cycle ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s.mem_valid  <= 1'b0;
      s.mem_addr   <= '0;
      s.mem_wdata  <= '0;
      s.mem_wstrb  <= '0;
      m0.mem_ready <= 1'b0;
      m0.mem_rdata <= '0;
      m1.mem_ready <= 1'b0;
      m1.mem_rdata <= '0;
      grant        <= 1'b0;
      timeout_err  <= 1'b0;
      prefer       <= 1'b0;
      wdog         <= '0;
    end else begin
      m0.mem_ready <= 1'b0;
      m1.mem_ready <= 1'b0;
      timeout_err  <= 1'b0;
      if (do_grant) begin
        s.mem_valid <= 1'b1;
        s.mem_addr  <= grant_idx ? m1.mem_addr  : m0.mem_addr;
        s.mem_wdata <= grant_idx ? m1.mem_wdata : m0.mem_wdata;
        s.mem_wstrb <= grant_idx ? m1.mem_wstrb : m0.mem_wstrb;
        grant       <= grant_idx;
        wdog        <= '0;
      end
      if (state == BUSY && !do_done && !do_abort) begin
        wdog <= wdog + 1'b1;
      end
      if (do_done || do_abort) begin
        s.mem_valid <= 1'b0;
        timeout_err <= do_abort;
        prefer      <= ~grant;
        if (grant) begin
          m1.mem_rdata <= do_abort ? ERR_RDATA : s.mem_rdata;
          m1.mem_ready <= 1'b1;
        end else begin
          m0.mem_rdata <= do_abort ? ERR_RDATA : s.mem_rdata;
          m0.mem_ready <= 1'b1;
        end
      end
    end
  end

endmodule
